tx_ccsk_spread: RTL and testbench

Transmit-side CCSK spreader. Buffers 5-bit symbols from the framing logic and, on each symbol-slot pulse, fetches the matching 32-chip code word (S0..S31) from the shared CCSK code RAM. It presents the word in parallel and serialises it MSB-first at a programmable chip rate. It sits between the TX symbol formatter and the modulator and mirrors the receive-side CCSK correlator.

---
 rtl/tx_ccsk_spread.sv | 220 ++++++++++++++++++++++
 tb/tb_tx_ccsk_spread.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ccsk_spread.sv
// rtl/tx_ccsk_spread.sv - transmit-side CCSK spreader: symbol FIFO, code RAM fetch, MSB-first chip serialiser
//
// Ports:
//   logic_clk_in      logic clock, all state on the rising edge
//   logic_rst_in      asynchronous active-low reset
//   sym_in/sym_wr_in  5-bit symbol and its 1-clk write strobe into the FIFO
//   data_pulse_in     symbol-slot start pulse; pops one symbol when idle
//   err_clr_in        clears the sticky error flags (a coincident set wins)
//   ccsk_ram_addr     code RAM address (the popped symbol), held between fetches
//   data_ccsk_seq     code RAM read data, valid one clock after the address is sampled
//   data_ccsk_out     latched 32-chip code word
//   word_valid_out    1-clk strobe when data_ccsk_out is loaded
//   chip_out          serial chip, MSB first, CHIP_DIV clocks per chip
//   chip_valid_out    high while chips are emitted
//   busy_out          high whenever the slot FSM is not idle
//   fifo_level_out    FIFO occupancy 0..FIFO_DEPTH
//   err_flags_out     sticky flags: [0] overflow, [1] underflow, [2] slot overrun

module tx_ccsk_spread #(
    parameter int FIFO_DEPTH = 8,
    parameter int CHIP_DIV   = 10
) (
    input  logic        logic_clk_in,
    input  logic        logic_rst_in,
    input  logic [4:0]  sym_in,
    input  logic        sym_wr_in,
    input  logic        data_pulse_in,
    input  logic        err_clr_in,
    output logic [4:0]  ccsk_ram_addr,
    input  logic [31:0] data_ccsk_seq,
    output logic [31:0] data_ccsk_out,
    output logic        word_valid_out,
    output logic        chip_out,
    output logic        chip_valid_out,
    output logic        busy_out,
    output logic [4:0]  fifo_level_out,
    output logic [2:0]  err_flags_out
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DIV_W = $clog2(CHIP_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CHIP_DIV - 1);
    localparam logic [4:0]       LEVEL_FULL = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_level;

    logic [4:0]       r_addr;
    logic [31:0]      r_word;
    logic             r_word_valid;
    logic [4:0]       r_chip_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_err;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_ovf;
    logic w_pulse_idle;
    logic w_pop;
    logic w_unf;
    logic w_ovr;
    logic w_div_wrap;
    logic w_last_chip;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_full       = (r_level == LEVEL_FULL);
    assign w_empty      = (r_level == 5'd0);
    // A write into a full FIFO is dropped even if a pop happens on the
    // same edge: the full condition is judged on the current level.
    assign w_wr_ok      = sym_wr_in && !w_full;
    assign w_ovf        = sym_wr_in && w_full;
    assign w_pulse_idle = data_pulse_in && (r_state == S_IDLE);
    assign w_pop        = w_pulse_idle && !w_empty;
    assign w_unf        = w_pulse_idle && w_empty;
    // Any pulse outside IDLE is an overrun, including one on the final
    // SEND cycle: the state register still reads SEND on that edge.
    assign w_ovr        = data_pulse_in && (r_state != S_IDLE);
    assign w_div_wrap   = (r_div_cnt == DIV_LAST);
    assign w_last_chip  = (r_state == S_SEND) && (r_chip_cnt == 5'd31) && w_div_wrap;

    // ------------------------------------------------------------------
    // Symbol FIFO
    // ------------------------------------------------------------------
    // Storage carries no reset; clearing the pointers and level discards it.
    always_ff @(posedge logic_clk_in) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= sym_in;
        end
    end

    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= 5'd0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_level <= r_level + 5'd1;
                2'b01:   r_level <= r_level - 5'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_SEND;
            S_SEND:  if (w_last_chip) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch address, word latch and chip counters
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            r_addr       <= 5'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
            r_chip_cnt   <= 5'd0;
            r_div_cnt    <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (w_pop) begin
                r_addr <= r_mem[r_rd_ptr];
            end
            case (r_state)
                S_WAIT: begin
                    // RAM data for the address sampled on the FETCH edge.
                    r_word       <= data_ccsk_seq;
                    r_word_valid <= 1'b1;
                    r_chip_cnt   <= 5'd0;
                    r_div_cnt    <= '0;
                end
                S_SEND: begin
                    if (w_div_wrap) begin
                        r_div_cnt  <= '0;
                        // Wraps 31 -> 0 exactly as the FSM leaves SEND.
                        r_chip_cnt <= r_chip_cnt + 5'd1;
                    end else begin
                        r_div_cnt  <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_chip_cnt <= r_chip_cnt;
                    r_div_cnt  <= r_div_cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set on the same edge as a clear survives
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk_in or negedge logic_rst_in) begin
        if (!logic_rst_in) begin
            r_err <= 3'b000;
        end else begin
            r_err <= (err_clr_in ? 3'b000 : r_err) | {w_ovr, w_unf, w_ovf};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Chip outputs decode straight from the state register so an
    // asynchronous reset forces them low without waiting for a clock.
    always_comb begin
        chip_valid_out = 1'b0;
        chip_out       = 1'b0;
        if (r_state == S_SEND) begin
            chip_valid_out = 1'b1;
            chip_out       = r_word[5'd31 - r_chip_cnt];
        end
    end

    assign busy_out       = (r_state != S_IDLE);
    assign ccsk_ram_addr  = r_addr;
    assign data_ccsk_out  = r_word;
    assign word_valid_out = r_word_valid;
    assign fifo_level_out = r_level;
    assign err_flags_out  = r_err;

endmodule

// File: tb/tb_tx_ccsk_spread.sv
// tb/tb_tx_ccsk_spread.sv - self-checking bench for tx_ccsk_spread against a queue-based reference model

module tb_tx_ccsk_spread;

    localparam int DEPTH = 8;
    localparam int CD    = 4;
    localparam int SLOT  = 32 * CD + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  sym = 5'd0;
    logic        sym_wr = 1'b0;
    logic        pulse = 1'b0;
    logic        err_clr = 1'b0;
    logic [4:0]  addr;
    logic [31:0] ram_q = 32'd0;
    logic [31:0] word;
    logic        wv;
    logic        chip;
    logic        cv;
    logic        busy;
    logic [4:0]  level;
    logic [2:0]  err;

    logic [31:0] ram_tbl [32];

    tx_ccsk_spread #(.FIFO_DEPTH(DEPTH), .CHIP_DIV(CD)) dut (
        .logic_clk_in   (clk),
        .logic_rst_in   (rst_n),
        .sym_in         (sym),
        .sym_wr_in      (sym_wr),
        .data_pulse_in  (pulse),
        .err_clr_in     (err_clr),
        .ccsk_ram_addr  (addr),
        .data_ccsk_seq  (ram_q),
        .data_ccsk_out  (word),
        .word_valid_out (wv),
        .chip_out       (chip),
        .chip_valid_out (cv),
        .busy_out       (busy),
        .fifo_level_out (level),
        .err_flags_out  (err)
    );

    always #5 clk = ~clk;

    // Code RAM: registered read, data valid one clock after the address.
    always @(posedge clk) ram_q <= ram_tbl[addr];

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [4:0] q[$];
    logic [2:0] m_err = 3'b000;
    bit         e_popped;
    logic [4:0] e_sym;

    // Observations from the last slot
    logic [4:0]   o_addr;
    int           o_busy_end;
    bit           o_wv3, o_wv_bad, o_cv_ok;
    logic         o_cv_after;
    logic [31:0]  o_word;
    logic [127:0] o_samp;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] spread(input logic [31:0] w);
        logic [127:0] r;
        for (int k = 0; k < 32 * CD; k++) r[127 - k] = w[31 - k / CD];
        return r;
    endfunction

    task automatic load_formula_table;
        for (int s = 0; s < 32; s++) ram_tbl[s] = {27'h0, 5'(s)} ^ 32'hA5A5_F00F;
    endtask

    task automatic wr(input logic [4:0] s, input bit clr);
        sym = s; sym_wr = 1'b1; err_clr = clr;
        tick;
        sym_wr = 1'b0; err_clr = 1'b0;
        if (clr) m_err = 3'b000;
        if (q.size() < DEPTH) q.push_back(s);
        else m_err[0] = 1'b1;
    endtask

    task automatic clear_errs;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        m_err = 3'b000;
    endtask

    // Issues one slot pulse (plus an optional stray pulse at cycle extra_at)
    // and records what the DUT did until it is idle again.
    task automatic do_slot(input int extra_at);
        int cyc;
        e_popped = (q.size() > 0);
        e_sym = 5'd0;
        if (e_popped) e_sym = q.pop_front();
        else m_err[1] = 1'b1;
        if (e_popped && extra_at > 0) m_err[2] = 1'b1;
        o_wv3 = 0; o_wv_bad = 0; o_cv_ok = 1; o_word = '0; o_samp = '0;
        pulse = 1'b1;
        tick;
        pulse = 1'b0;
        cyc = 1;
        o_addr = addr;
        if (wv) o_wv_bad = 1;
        while (busy && cyc < SLOT + 20) begin
            if (cyc == extra_at) pulse = 1'b1;
            tick;
            pulse = 1'b0;
            cyc++;
            if (wv) begin
                if (cyc == 3) o_wv3 = 1;
                else o_wv_bad = 1;
            end
            if (cyc == 3) o_word = word;
            if (cyc >= 3 && cyc < 3 + 32 * CD) begin
                o_samp[127 - (cyc - 3)] = chip;
                if (!cv) o_cv_ok = 0;
            end
        end
        o_busy_end = cyc;
        o_cv_after = cv;
    endtask

    task automatic test_reset;
        tick;
        checks++;
        if ({addr, word, wv, chip, cv, busy, level, err} !== '0) begin
            errors++;
            $display("FAIL reset_held got addr=%0d word=%h wv=%b chip=%b cv=%b busy=%b lvl=%0d err=%b exp all zero",
                     addr, word, wv, chip, cv, busy, level, err);
        end
        rst_n = 1'b1;
        tick;
        tick;
        checks++;
        if ({addr, word, wv, chip, cv, busy, level, err} !== '0) begin
            errors++;
            $display("FAIL reset_released got addr=%0d word=%h busy=%b lvl=%0d err=%b exp all zero",
                     addr, word, busy, level, err);
        end
    endtask

    task automatic test_single;
        logic [31:0] exp_w;
        wr(5'd5, 0);
        checks++;
        if (level !== 5'd1) begin errors++; $display("FAIL single_level_after_write got %0d exp 1", level); end
        do_slot(0);
        exp_w = {27'h0, 5'd5} ^ 32'hA5A5_F00F;
        checks++;
        if (o_addr !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", o_addr); end
        checks++;
        if (!(o_wv3 && !o_wv_bad)) begin errors++; $display("FAIL single_word_valid got at3=%0d stray=%0d exp 1 0", o_wv3, o_wv_bad); end
        checks++;
        if (o_word !== exp_w) begin errors++; $display("FAIL single_word got %h exp %h", o_word, exp_w); end
        checks++;
        if (o_samp !== spread(exp_w) || !o_cv_ok) begin
            errors++; $display("FAIL single_chips got %h cv_ok=%0d exp %h", o_samp, o_cv_ok, spread(exp_w));
        end
        checks++;
        if (o_busy_end !== SLOT || o_cv_after !== 1'b0) begin
            errors++; $display("FAIL single_busy_end got %0d cv=%b exp %0d 0", o_busy_end, o_cv_after, SLOT);
        end
        checks++;
        if (err !== m_err) begin errors++; $display("FAIL single_err got %b exp %b", err, m_err); end
    endtask

    task automatic test_back_to_back;
        wr(5'd0, 0); wr(5'd31, 0); wr(5'd17, 0);
        checks++;
        if (level !== 5'd3) begin errors++; $display("FAIL b2b_level_start got %0d exp 3", level); end
        for (int i = 0; i < 3; i++) begin
            do_slot(0);
            checks++;
            if (o_addr !== e_sym) begin errors++; $display("FAIL b2b_addr[%0d] got %0d exp %0d", i, o_addr, e_sym); end
            checks++;
            if (o_samp !== spread(ram_tbl[e_sym]) || !o_cv_ok || !o_wv3) begin
                errors++; $display("FAIL b2b_chips[%0d] got %h exp %h", i, o_samp, spread(ram_tbl[e_sym]));
            end
            checks++;
            if (level !== 5'(q.size())) begin errors++; $display("FAIL b2b_level[%0d] got %0d exp %0d", i, level, q.size()); end
        end
        checks++;
        if (err !== 3'b000) begin errors++; $display("FAIL b2b_err got %b exp 000", err); end
    endtask

    task automatic test_underflow_overrun;
        do_slot(0);
        checks++;
        if (o_busy_end !== 1) begin errors++; $display("FAIL unf_busy got end=%0d exp 1", o_busy_end); end
        checks++;
        if (err !== 3'b010 || err !== m_err) begin errors++; $display("FAIL unf_err got %b exp 010", err); end
        checks++;
        if (addr !== 5'd17) begin errors++; $display("FAIL unf_addr_hold got %0d exp 17", addr); end
        wr(5'd9, 0); wr(5'd22, 0);
        do_slot(50);
        checks++;
        if (o_addr !== 5'd9 || o_samp !== spread(ram_tbl[9])) begin
            errors++; $display("FAIL ovr_slot got addr=%0d exp 9", o_addr);
        end
        checks++;
        if (level !== 5'd1) begin errors++; $display("FAIL ovr_no_pop got level %0d exp 1", level); end
        checks++;
        if (err !== 3'b110 || err !== m_err) begin errors++; $display("FAIL ovr_err got %b exp 110", err); end
        do_slot(0);
        checks++;
        if (o_addr !== 5'd22 || level !== 5'd0) begin
            errors++; $display("FAIL ovr_follow got addr=%0d lvl=%0d exp 22 0", o_addr, level);
        end
    endtask

    task automatic test_overflow;
        clear_errs;
        checks++;
        if (err !== 3'b000) begin errors++; $display("FAIL ovf_clear got %b exp 000", err); end
        for (int i = 0; i < 9; i++) wr(5'($urandom_range(0, 31)), 0);
        checks++;
        if (level !== 5'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
        checks++;
        if (err !== 3'b001 || err !== m_err) begin errors++; $display("FAIL ovf_err got %b exp 001", err); end
        for (int i = 0; i < 8; i++) begin
            do_slot(0);
            checks++;
            if (o_addr !== e_sym || o_word !== ram_tbl[e_sym]) begin
                errors++; $display("FAIL ovf_readout[%0d] got %0d exp %0d", i, o_addr, e_sym);
            end
        end
        do_slot(0);
        checks++;
        if (o_busy_end !== 1 || level !== 5'd0 || err !== 3'b011) begin
            errors++; $display("FAIL ovf_ninth_absent got end=%0d lvl=%0d err=%b exp 1 0 011", o_busy_end, level, err);
        end
    endtask

    task automatic test_simultaneous;
        int n;
        logic [4:0] popped;
        clear_errs;
        wr(5'd3, 0); wr(5'd4, 0); wr(5'd6, 0);
        sym = 5'd12; sym_wr = 1'b1; pulse = 1'b1;
        tick;
        sym_wr = 1'b0; pulse = 1'b0;
        popped = q.pop_front();
        q.push_back(5'd12);
        checks++;
        if (level !== 5'd3) begin errors++; $display("FAIL simul_wr_pop_level got %0d exp 3", level); end
        checks++;
        if (addr !== popped) begin errors++; $display("FAIL simul_wr_pop_addr got %0d exp %0d", addr, popped); end
        n = 0;
        while (busy && n < SLOT + 20) begin tick; n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL simul_slot_timeout got busy %b exp 0", busy); end
        for (int i = 0; i < 5; i++) wr(5'($urandom_range(0, 31)), 0);
        wr(5'd1, 1);
        checks++;
        if (err !== 3'b001 || err !== m_err) begin errors++; $display("FAIL simul_clr_vs_ovf got %b exp 001", err); end
        for (int i = 0; i < 8; i++) begin
            do_slot(0);
            checks++;
            if (o_addr !== e_sym) begin errors++; $display("FAIL simul_drain[%0d] got %0d exp %0d", i, o_addr, e_sym); end
        end
    endtask

    task automatic test_random;
        int extra;
        clear_errs;
        for (int s = 0; s < 32; s++) ram_tbl[s] = $urandom;
        for (int it = 0; it < 12; it++) begin
            for (int w = $urandom_range(0, 2); w > 0; w--) wr(5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0));
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SLOT - 1)) : 0;
            do_slot(extra);
            if (e_popped) begin
                checks++;
                if (o_addr !== e_sym || o_word !== ram_tbl[e_sym] || o_samp !== spread(ram_tbl[e_sym]) ||
                    !o_cv_ok || !o_wv3 || o_wv_bad || o_busy_end !== SLOT) begin
                    errors++;
                    $display("FAIL rand_slot[%0d] got addr=%0d word=%h end=%0d exp addr=%0d word=%h end=%0d",
                             it, o_addr, o_word, o_busy_end, e_sym, ram_tbl[e_sym], SLOT);
                end
            end else begin
                checks++;
                if (o_busy_end !== 1) begin errors++; $display("FAIL rand_empty[%0d] got end=%0d exp 1", it, o_busy_end); end
            end
            checks++;
            if (err !== m_err || level !== 5'(q.size())) begin
                errors++; $display("FAIL rand_state[%0d] got err=%b lvl=%0d exp err=%b lvl=%0d", it, err, level, m_err, q.size());
            end
        end
    endtask

    task automatic test_reset_mid_send;
        load_formula_table;
        clear_errs;
        while (q.size() > 0) do_slot(0);
        wr(5'd5, 0); wr(5'd7, 0); wr(5'd8, 0);
        pulse = 1'b1;
        tick;
        pulse = 1'b0;
        for (int c = 1; c < 3 + 10 * CD; c++) tick;
        checks++;
        if (cv !== 1'b1 || level !== 5'd2) begin errors++; $display("FAIL rst_mid_pre got cv=%b lvl=%0d exp 1 2", cv, level); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (cv !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async got cv=%b lvl=%0d busy=%b exp 0 0 0", cv, level, busy);
        end
        checks++;
        if (word !== 32'd0 || addr !== 5'd0 || chip !== 1'b0 || wv !== 1'b0 || err !== 3'b000) begin
            errors++; $display("FAIL rst_mid_outputs got word=%h addr=%0d chip=%b err=%b exp zeros", word, addr, chip, err);
        end
        tick;
        tick;
        rst_n = 1'b1;
        q.delete();
        m_err = 3'b000;
        tick;
        wr(5'd5, 0);
        do_slot(0);
        checks++;
        if (o_addr !== 5'd5 || o_word !== ram_tbl[5] || !o_wv3 || o_wv_bad) begin
            errors++; $display("FAIL rst_mid_after_word got addr=%0d word=%h exp 5 %h", o_addr, o_word, ram_tbl[5]);
        end
        checks++;
        if (o_samp !== spread(ram_tbl[5]) || o_busy_end !== SLOT || err !== 3'b000) begin
            errors++; $display("FAIL rst_mid_after_chips got end=%0d err=%b exp %0d 000", o_busy_end, err, SLOT);
        end
    endtask

    initial begin
        load_formula_table;
        test_reset;
        test_single;
        test_back_to_back;
        test_underflow_overrun;
        test_overflow;
        test_simultaneous;
        test_random;
        test_reset_mid_send;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
